// File: rtl/pipe_control_unit_if.sv
// Control-unit bus: ID instruction and EX flags in, decoded pipeline controls out.
interface pipe_control_unit_if #(
  parameter int unsigned ALU_CTRL_W = 3
) ();
  logic [31:0]           InstrD;
  logic                  FlushE;
  logic                  ZeroE;
  logic                  LtE;
  logic [2:0]            ImmSrcD;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic                  ALUSrcE;
  logic [1:0]            PCSrcE;
  logic [1:0]            ResultSrcE;
  logic                  MemWriteM;
  logic                  RegWriteM;
  logic [1:0]            ResultSrcW;
  logic                  RegWriteW;
  logic                  IllegalE;

  modport master (
    output InstrD, FlushE, ZeroE, LtE,
    input  ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, ResultSrcE,
           MemWriteM, RegWriteM, ResultSrcW, RegWriteW, IllegalE
  );

  modport slave (
    input  InstrD, FlushE, ZeroE, LtE,
    output ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, ResultSrcE,
           MemWriteM, RegWriteM, ResultSrcW, RegWriteW, IllegalE
  );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined RV32 control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// EX-stage branch/jump resolution.
module pipe_control_unit #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter bit          EXT_BRANCH = 1'b1,
  parameter bit          EXT_ALU    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  pipe_control_unit_if.slave bus
);
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_PSB = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic                reg_write;
    logic [1:0]          result_src;
    logic                mem_write;
    logic                jump;
    logic                jump_reg;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_ctrl;
    logic                alu_src;
    logic [2:0]          funct3;
    logic                illegal;
  } idex_t;

  logic [6:0] w_op;
  logic [2:0] w_funct3;
  logic       w_instr30;
  logic       w_unused_instr_bits;
  logic       w_legal;
  logic [2:0] w_imm_src;
  idex_t      w_dec;
  logic       w_cond;

  idex_t      r_idex;
  logic       r_reg_write_m;
  logic       r_mem_write_m;
  logic [1:0] r_result_src_m;
  logic       r_reg_write_w;
  logic [1:0] r_result_src_w;

  assign w_op      = bus.InstrD[6:0];
  assign w_funct3  = bus.InstrD[14:12];
  assign w_instr30 = bus.InstrD[30];
  assign w_unused_instr_bits = ^{bus.InstrD[31], bus.InstrD[29:15], bus.InstrD[11:7]};

  // ID decode; any unsupported encoding collapses to an all-zero word with illegal set
  always_comb begin
    w_dec        = '0;
    w_dec.funct3 = w_funct3;
    w_imm_src    = IMM_I;
    w_legal      = 1'b1;
    case (w_op)
      OP_R: begin
        w_dec.reg_write = 1'b1;
        case (w_funct3)
          3'b000:  w_dec.alu_ctrl = w_instr30 ? ALU_SUB : ALU_ADD;
          3'b111:  w_dec.alu_ctrl = ALU_AND;
          3'b110:  w_dec.alu_ctrl = ALU_OR;
          3'b010:  w_dec.alu_ctrl = ALU_SLT;
          3'b100: begin
            w_dec.alu_ctrl = ALU_XOR;
            w_legal        = EXT_ALU;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_I: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        case (w_funct3)
          3'b000:  w_dec.alu_ctrl = ALU_ADD;
          3'b111:  w_dec.alu_ctrl = ALU_AND;
          3'b110:  w_dec.alu_ctrl = ALU_OR;
          3'b010: begin
            w_dec.alu_ctrl = ALU_SLT;
            w_legal        = EXT_ALU;
          end
          3'b100: begin
            w_dec.alu_ctrl = ALU_XOR;
            w_legal        = EXT_ALU;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_LW: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b01;
        w_legal          = (w_funct3 == 3'b010);
      end
      OP_SW: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_imm_src       = IMM_S;
        w_legal         = (w_funct3 == 3'b010);
      end
      OP_BR: begin
        w_dec.branch   = 1'b1;
        w_dec.alu_ctrl = ALU_SUB;
        w_imm_src      = IMM_B;
        case (w_funct3)
          3'b000:                 w_legal = 1'b1;
          3'b001, 3'b100, 3'b101: w_legal = EXT_BRANCH;
          default:                w_legal = 1'b0;
        endcase
      end
      OP_JAL: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.jump       = 1'b1;
        w_imm_src        = IMM_J;
      end
      OP_JALR: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.jump_reg   = 1'b1;
        w_legal          = (w_funct3 == 3'b000);
      end
      OP_LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_ctrl  = ALU_PSB;
        w_imm_src       = IMM_U;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
      w_imm_src     = IMM_I;
    end
  end

  // ID/EX register; reset and flush both load the all-zero bubble
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) r_idex <= '0;
    else                     r_idex <= w_dec;
  end

  // EX/MEM and MEM/WB registers; an illegal EX entry never forwards write enables
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= 2'b00;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 2'b00;
    end else begin
      r_reg_write_m  <= r_idex.reg_write & ~r_idex.illegal;
      r_mem_write_m  <= r_idex.mem_write & ~r_idex.illegal;
      r_result_src_m <= r_idex.result_src;
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
    end
  end

  // EX branch condition selected by the carried funct3
  always_comb begin
    w_cond = 1'b0;
    case (r_idex.funct3)
      3'b000:  w_cond = bus.ZeroE;
      3'b001:  w_cond = ~bus.ZeroE;
      3'b100:  w_cond = bus.LtE;
      3'b101:  w_cond = ~bus.LtE;
      default: w_cond = 1'b0;
    endcase
  end

  // Next-PC select: JALR over JAL over taken branch
  always_comb begin
    bus.PCSrcE = 2'b00;
    if (r_idex.jump_reg)                  bus.PCSrcE = 2'b10;
    else if (r_idex.jump)                 bus.PCSrcE = 2'b01;
    else if (r_idex.branch && w_cond)     bus.PCSrcE = 2'b01;
  end

  assign bus.ImmSrcD     = w_imm_src;
  assign bus.ALUControlE = ALU_CTRL_W'(r_idex.alu_ctrl);
  assign bus.ALUSrcE     = r_idex.alu_src;
  assign bus.ResultSrcE  = r_idex.result_src;
  assign bus.IllegalE    = r_idex.illegal;
  assign bus.MemWriteM   = r_mem_write_m;
  assign bus.RegWriteM   = r_reg_write_m;
  assign bus.ResultSrcW  = r_result_src_w;
  assign bus.RegWriteW   = r_reg_write_w;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed table-driven bench for pipe_control_unit (extended and base configurations).
module tb_pipe_control_unit;
  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_XOR  = 32'h003140B3;
  localparam logic [31:0] I_ADDI = 32'h00510093;
  localparam logic [31:0] I_SLTI = 32'h00512093;
  localparam logic [31:0] I_LW   = 32'h0002A083;
  localparam logic [31:0] I_LB   = 32'h00028083;
  localparam logic [31:0] I_SW   = 32'h0012A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_BGE  = 32'h0020D463;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_LUI  = 32'h123450B7;

  typedef struct packed {
    logic [2:0] alu;
    logic       src;
    logic [1:0] pc;
    logic [1:0] rse;
    logic       ill;
    logic       mwm;
    logic       rwm;
    logic [1:0] rsw;
    logic       rww;
    logic [2:0] imm;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        flush;
    logic [31:0] instr;
    logic        zero;
    logic        lt;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] instr;
  logic        zero;
  logic        lt;
  int          n_vec;
  int          n_err;
  vec_t        vecs[$];

  pipe_control_unit_if #(.ALU_CTRL_W(3)) if1 ();
  pipe_control_unit_if #(.ALU_CTRL_W(4)) if0 ();

  assign if1.InstrD = instr;
  assign if1.FlushE = flush;
  assign if1.ZeroE  = zero;
  assign if1.LtE    = lt;
  assign if0.InstrD = instr;
  assign if0.FlushE = flush;
  assign if0.ZeroE  = zero;
  assign if0.LtE    = lt;

  pipe_control_unit #(.ALU_CTRL_W(3), .EXT_BRANCH(1'b1), .EXT_ALU(1'b1)) dut1 (
    .clk(clk), .reset(rst), .bus(if1)
  );
  pipe_control_unit #(.ALU_CTRL_W(4), .EXT_BRANCH(1'b0), .EXT_ALU(1'b0)) dut0 (
    .clk(clk), .reset(rst), .bus(if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic r, input logic f,
                              input logic [31:0] ins, input logic z, input logic l,
                              input logic [2:0] alu, input logic src, input logic [1:0] pc,
                              input logic [1:0] rse, input logic ill, input logic mwm,
                              input logic rwm, input logic [1:0] rsw, input logic rww,
                              input logic [2:0] imm);
    vec_t v;
    v.name  = nm;
    v.rst   = r;
    v.flush = f;
    v.instr = ins;
    v.zero  = z;
    v.lt    = l;
    v.exp   = '{alu, src, pc, rse, ill, mwm, rwm, rsw, rww, imm};
    return v;
  endfunction

  function automatic out_t act1();
    out_t o;
    o.alu = if1.ALUControlE;
    o.src = if1.ALUSrcE;
    o.pc  = if1.PCSrcE;
    o.rse = if1.ResultSrcE;
    o.ill = if1.IllegalE;
    o.mwm = if1.MemWriteM;
    o.rwm = if1.RegWriteM;
    o.rsw = if1.ResultSrcW;
    o.rww = if1.RegWriteW;
    o.imm = if1.ImmSrcD;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic f, input logic z, input logic l);
    instr = ins;
    flush = f;
    zero  = z;
    lt    = l;
    rst   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_t got;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    flush = 1'b0;
    instr = I_ADD;
    zero  = 1'b0;
    lt    = 1'b0;

    //               name            rst fl instr   z  lt  alu src pc rse ill mwm rwm rsw rww imm
    vecs.push_back(mk("rst_a",        1, 0, I_ADD,  0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk("rst_b",        1, 0, I_ADD,  0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk("add_e",        0, 0, I_ADD,  0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk("lw_e",         0, 0, I_LW,   0, 0,  0,  1, 0, 1,  0,  0,  1,  0,  0,  0));
    vecs.push_back(mk("sw_e",         0, 0, I_SW,   0, 0,  0,  1, 0, 0,  0,  0,  1,  0,  1,  1));
    vecs.push_back(mk("addi_e",       0, 0, I_ADDI, 0, 0,  0,  1, 0, 0,  0,  1,  0,  1,  1,  0));
    vecs.push_back(mk("beq_taken",    0, 0, I_BEQ,  1, 0,  1,  0, 1, 0,  0,  0,  1,  0,  0,  2));
    vecs.push_back(mk("beq_not",      0, 0, I_BEQ,  0, 0,  1,  0, 0, 0,  0,  0,  0,  0,  1,  2));
    vecs.push_back(mk("bne_taken",    0, 0, I_BNE,  0, 0,  1,  0, 1, 0,  0,  0,  0,  0,  0,  2));
    vecs.push_back(mk("bne_not",      0, 0, I_BNE,  1, 0,  1,  0, 0, 0,  0,  0,  0,  0,  0,  2));
    vecs.push_back(mk("blt_taken",    0, 0, I_BLT,  0, 1,  1,  0, 1, 0,  0,  0,  0,  0,  0,  2));
    vecs.push_back(mk("bge_not",      0, 0, I_BGE,  0, 1,  1,  0, 0, 0,  0,  0,  0,  0,  0,  2));
    vecs.push_back(mk("bge_taken",    0, 0, I_BGE,  0, 0,  1,  0, 1, 0,  0,  0,  0,  0,  0,  2));
    vecs.push_back(mk("jalr",         0, 0, I_JALR, 0, 0,  0,  1, 2, 2,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk("jal",          0, 0, I_JAL,  0, 0,  0,  0, 1, 2,  0,  0,  1,  0,  0,  3));
    vecs.push_back(mk("lui",          0, 0, I_LUI,  0, 0,  5,  1, 0, 0,  0,  0,  1,  2,  1,  4));
    vecs.push_back(mk("xor",          0, 0, I_XOR,  0, 0,  6,  0, 0, 0,  0,  0,  1,  2,  1,  0));
    vecs.push_back(mk("zero_word",    0, 0, 32'h0,  0, 0,  0,  0, 0, 0,  1,  0,  1,  0,  1,  0));
    vecs.push_back(mk("add_post_ill", 0, 0, I_ADD,  0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  1,  0));
    vecs.push_back(mk("flush_sw",     0, 1, I_SW,   0, 0,  0,  0, 0, 0,  0,  0,  1,  0,  0,  1));
    vecs.push_back(mk("add_post_fl",  0, 0, I_ADD,  0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  1,  0));
    vecs.push_back(mk("rst_and_flush",1, 1, I_SW,   0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  1));
    vecs.push_back(mk("slti",         0, 0, I_SLTI, 0, 0,  4,  1, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk("lb_illegal",   0, 0, I_LB,   0, 0,  0,  0, 0, 0,  1,  0,  1,  0,  0,  0));
    vecs.push_back(mk("add_flags",    0, 0, I_ADD,  1, 1,  0,  0, 0, 0,  0,  0,  0,  0,  1,  0));
    vecs.push_back(mk("flush_bubble", 0, 1, I_ADD,  1, 1,  0,  0, 0, 0,  0,  0,  1,  0,  0,  0));
    vecs.push_back(mk("add_post_bub", 0, 0, I_ADD,  0, 0,  0,  0, 0, 0,  0,  0,  0,  0,  1,  0));

    foreach (vecs[i]) begin
      instr = vecs[i].instr;
      flush = vecs[i].flush;
      zero  = vecs[i].zero;
      lt    = vecs[i].lt;
      rst   = vecs[i].rst;
      @(posedge clk);
      #1;
      got = act1();
      n_vec++;
      if (got !== vecs[i].exp) begin
        n_err++;
        $display("FAIL row %0d %s: got %h expected %h", i, vecs[i].name, got, vecs[i].exp);
      end
    end

    // PCSrcE keeps reflecting EX while FlushE is high, then the bubble lands
    step(I_BEQ, 1'b0, 1'b1, 1'b0);
    chk("beq_pre_flush", 32'(if1.PCSrcE), 32'd1);
    instr = I_SW;
    flush = 1'b1;
    #1;
    chk("pcsrc_during_flush", 32'(if1.PCSrcE), 32'd1);
    @(posedge clk);
    #1;
    chk("flush_e_zero", 32'({if1.ALUControlE, if1.ALUSrcE, if1.PCSrcE, if1.ResultSrcE, if1.IllegalE}), 32'd0);
    step(I_ADD, 1'b0, 1'b0, 1'b0);
    chk("flush_no_memwrite", 32'(if1.MemWriteM), 32'd0);

    // Base configuration: extended branches/ALU ops are illegal, ALUControl zero-filled
    step(I_BNE, 1'b0, 1'b0, 1'b0);
    chk("ext0_bne_illegal", 32'(if0.IllegalE), 32'd1);
    chk("ext0_bne_pcsrc", 32'(if0.PCSrcE), 32'd0);
    chk("ext1_bne_taken", 32'(if1.PCSrcE), 32'd1);
    step(I_ADD, 1'b0, 1'b0, 1'b0);
    chk("ext0_illegal_one_cycle", 32'(if0.IllegalE), 32'd0);
    chk("ext0_add_alu", 32'(if0.ALUControlE), 32'h0);
    chk("ext0_bne_no_regwrite_m", 32'(if0.RegWriteM), 32'd0);
    step(I_XOR, 1'b0, 1'b0, 1'b0);
    chk("ext0_xor_illegal", 32'(if0.IllegalE), 32'd1);
    chk("ext1_xor_alu", 32'(if1.ALUControlE), 32'h6);
    step(I_SUB, 1'b0, 1'b0, 1'b0);
    chk("ext0_sub_alu", 32'(if0.ALUControlE), 32'h1);
    chk("ext0_xor_no_regwrite_m", 32'(if0.RegWriteM), 32'd0);
    chk("ext0_add_regwrite_w", 32'(if0.RegWriteW), 32'd1);
    step(I_LUI, 1'b0, 1'b0, 1'b0);
    chk("ext0_lui_alu", 32'(if0.ALUControlE), 32'h5);
    chk("ext0_xor_no_regwrite_w", 32'(if0.RegWriteW), 32'd0);
    step(I_SLTI, 1'b0, 1'b0, 1'b0);
    chk("ext0_slti_illegal", 32'(if0.IllegalE), 32'd1);
    chk("ext1_slti_legal", 32'(if1.IllegalE), 32'd0);
    step(I_BEQ, 1'b0, 1'b1, 1'b0);
    chk("ext0_beq_taken", 32'(if0.PCSrcE), 32'd1);
    chk("ext0_beq_imm_b", 32'(if0.ImmSrcD), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
Pipelined RISC-V control unit for the 5-stage core. It decodes the ID-stage instruction and carries the control bits through the ID/EX, EX/MEM and MEM/WB registers. It resolves branches and jumps in EX from ALU flags. FlushE inserts bubbles for the hazard unit, and parameters enable the extended branch and ALU opcodes.

Parameters:
ALU_CTRL_W, 3, width of ALUControl; must be >= 3, upper bits zero-filled.
EXT_BRANCH, 1, 1 = decode BNE/BLT/BGE in addition to BEQ; 0 = those funct3 values are illegal.
EXT_ALU, 1, 1 = decode XOR/XORI (110) and SLTI (100); 0 = illegal.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
InstrD  in  32  instruction in ID
FlushE  in  1  turn ID/EX contents into a bubble next edge
ZeroE  in  1  ALU result == 0 (EX)
LtE  in  1  signed SrcA < SrcB (EX)
ImmSrcD  out  3  immediate format, combinational from InstrD
ALUControlE  out  ALU_CTRL_W  ALU op in EX
ALUSrcE  out  1  1 = immediate operand
PCSrcE  out  2  00 PC+4, 01 PC+imm, 10 ALU result (JALR); combinational in EX
ResultSrcE  out  2  for load-use detection
MemWriteM  out  1  data memory write enable
RegWriteM  out  1  for forwarding
ResultSrcW  out  2  00 ALU, 01 mem, 10 PC+4
RegWriteW  out  1  register file write enable
IllegalE  out  1  unsupported opcode/funct in EX

Behaviour:
- Decode (ID, combinational):
  - R 0110011: RegWrite. funct3 000 ADD/SUB by Instr[30], 111 AND, 110 OR, 010 SLT, 100 XOR (EXT_ALU).
  - I-ALU 0010011: RegWrite, ALUSrc, ImmSrc I. 000 ADDI, 111 ANDI, 110 ORI, 010/100 SLTI/XORI (EXT_ALU).
  - LW 0000011 funct3 010: RegWrite, ALUSrc, ResultSrc 01, ADD.
  - SW 0100011 funct3 010: MemWrite, ALUSrc, ImmSrc S, ADD.
  - Branch 1100011: ImmSrc B, SUB. Branch and funct3 are carried to EX.
  - JAL 1101111: RegWrite, ImmSrc J, ResultSrc 10, Jump.
  - JALR 1100111: RegWrite, ALUSrc, ImmSrc I, ADD, ResultSrc 10, JumpReg.
  - LUI 0110111: RegWrite, ALUSrc, ImmSrc U, ALU 101 (pass B).
- ALUControl codes: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 passB, 110 xor.
- ImmSrc codes: 000 I, 001 S, 010 B, 011 J, 100 U.
- Any other opcode/funct, including the all-zero word, is illegal:
  - Illegal decodes set Illegal=1 with RegWrite=MemWrite=Branch=Jump=0.
  - IllegalE is asserted for exactly one cycle in EX and never propagates write enables.
- Pipeline registers: ID/EX, EX/MEM and MEM/WB, all updated every rising edge. There is no stall input; the hazard unit holds IF/ID externally.
- Latency: decode of InstrD appears on the E outputs 1 cycle later, MemWriteM/RegWriteM 2 cycles later, RegWriteW/ResultSrcW 3 cycles later.
- PCSrcE priority: JumpRegE -> 10; JumpE -> 01; BranchE and cond -> 01; else 00.
  - cond by funct3E: 000 ZeroE, 001 !ZeroE, 100 LtE, 101 !LtE.
  - 001/100/101 are valid only when EXT_BRANCH=1.
- FlushE=1 loads the ID/EX register with the reset bubble (all zero). PCSrcE in the same cycle still reflects the current EX contents.
- Reset: all pipeline registers clear to zero on the next edge, so every E/M/W output reads 0 (PCSrcE=00, IllegalE=0). Reset has priority over FlushE.
- Reset mid-stream: the in-flight instructions in all three stages are discarded.
- ImmSrcD is not reset and follows InstrD.
- Bubbles (all-zero ID/EX) must produce no write, no branch and no IllegalE.

Test Plan:
- Reset held 2 cycles with InstrD=ADD x1,x2,x3 -> all E/M/W outputs 0. Release -> next cycle ALUControlE=000, ALUSrcE=0; +1 RegWriteM=1; +1 RegWriteW=1, ResultSrcW=00.
- LW 0x0002A083 then SW 0x0012A023 back-to-back -> ResultSrcE=01, then MemWriteM=1 one cycle after the SW is in EX. RegWriteW=1 for LW only, with ResultSrcW=01.
- BEQ in EX with ZeroE=1 -> PCSrcE=01; ZeroE=0 -> 00. BNE (EXT_BRANCH=1) with ZeroE=0 -> 01. BLT with LtE=1 -> 01. With EXT_BRANCH=0, BNE -> IllegalE=1, PCSrcE=00.
- JALR 0x000080E7 -> PCSrcE=10, ALUSrcE=1; 2 cycles later ResultSrcW=10, RegWriteW=1. JAL -> PCSrcE=01.
- FlushE asserted while SW is in ID -> next cycle all E outputs 0, and MemWriteM=0 the cycle after. FlushE and reset together -> outputs 0.
- InstrD=0x00000000 -> IllegalE=1 for one cycle, RegWriteM/RegWriteW/MemWriteM stay 0. XOR with EXT_ALU=1 -> ALUControlE=110.
